hd_word_stager: RTL and testbench

Sequential front/back-end for the 32-in/32-out combinational Hacker's-Delight benchmark cores (x0..x31 -> y0..y31). Assembles a 32-bit operand from a byte-wide valid/ready stream and holds it stable on the core inputs for a fixed settle window. It then captures the core's 32-bit result and presents it on a word-wide valid/ready output. One stager instance wraps exactly one core instance.

---
 rtl/hd_word_stager.sv | 143 ++++++++++++++
 tb/tb_hd_word_stager.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hd_word_stager.sv
// hd_word_stager: sequential front/back-end for one 32-in/32-out combinational core.
// It collects four bytes (LSB first) into an operand and drives that operand on core_x.
// The operand is held for SETTLE_CYCLES cycles. Then core_y is captured and presented
// on a word-wide valid/ready output.
//
// Optional feature: define HD_STAGER_PARITY_EN to add the in_par port. Each accepted
// byte is then checked for even parity; a bad byte sets the sticky err flag and poisons
// the current word.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    byte input handshake, in_data = operand byte
//   in_par               even-parity bit for in_data (HD_STAGER_PARITY_EN only)
//   core_x               operand to the core, stable from load until the output drains
//   core_y               core result, sampled in the CAPTURE state
//   out_valid/out_ready  result handshake, out_data = captured result
//   busy                 high unless idle in LOAD with no partial bytes
//   err                  sticky parity error (constant 0 without HD_STAGER_PARITY_EN)
module hd_word_stager #(
  parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
`ifdef HD_STAGER_PARITY_EN
  input  logic        in_par,
`endif
  output logic [31:0] core_x,
  input  logic [31:0] core_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {StLoad, StSettle, StCapture, StDrain} state_e;

  localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [3:0]      settle_q, settle_d;
  // Only lanes 0..2 are stored; lane 3 is the byte accepted on the loading cycle.
  logic [2:0][7:0] shadow_q, shadow_d;
  logic [31:0]     core_x_q, core_x_d;
  logic [31:0]     out_data_q, out_data_d;
  logic            poison_q, poison_d;
  logic            err_q, err_d;
  logic            bad_par;

`ifdef HD_STAGER_PARITY_EN
  assign bad_par = ^{in_data, in_par};
`else
  assign bad_par = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    settle_d   = settle_q;
    shadow_d   = shadow_q;
    core_x_d   = core_x_q;
    out_data_d = out_data_q;
    poison_d   = poison_q;
    err_d      = err_q;
    in_ready   = 1'b0;

    unique case (state_q)
      StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q != 2'd3) begin
            shadow_d[cnt_q] = in_data;
          end
          if (bad_par) begin
            err_d    = 1'b1;
            poison_d = 1'b1;
          end
          if (cnt_q == 2'd3) begin
            // A poisoned word is dropped: back to an empty LOAD, core_x untouched.
            poison_d = 1'b0;
            if (!(poison_q || bad_par)) begin
              core_x_d = {in_data, shadow_q[2], shadow_q[1], shadow_q[0]};
              settle_d = SettleLoad;
              state_d  = StSettle;
            end
          end
        end
      end
      StSettle: begin
        if (settle_q == 4'd0) begin
          state_d = StCapture;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      StCapture: begin
        out_data_d = core_y;
        state_d    = StDrain;
      end
      StDrain: begin
        if (out_ready) begin
          state_d = StLoad;
          cnt_d   = 2'd0;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StLoad;
      cnt_q      <= 2'd0;
      settle_q   <= 4'd0;
      shadow_q   <= '0;
      core_x_q   <= 32'd0;
      out_data_q <= 32'd0;
      poison_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      settle_q   <= settle_d;
      shadow_q   <= shadow_d;
      core_x_q   <= core_x_d;
      out_data_q <= out_data_d;
      poison_q   <= poison_d;
      err_q      <= err_d;
    end
  end

  assign core_x    = core_x_q;
  assign out_data  = out_data_q;
  assign out_valid = (state_q == StDrain);
  assign busy      = !((state_q == StLoad) && (cnt_q == 2'd0));
  assign err       = err_q;

endmodule

// File: tb/tb_hd_word_stager.sv
// Directed self-checking bench for hd_word_stager (SETTLE_CYCLES = 2).
// The core is modelled as y = swap16(x) ^ 32'hA5A50F0F; expected results are precomputed.
module tb_hd_word_stager;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
`ifdef HD_STAGER_PARITY_EN
  logic        in_par;
`endif
  logic [31:0] core_x;
  logic [31:0] core_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign core_y = {core_x[15:0], core_x[31:16]} ^ 32'hA5A50F0F;

  hd_word_stager #(.SETTLE_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef HD_STAGER_PARITY_EN
    .in_par    (in_par),
`endif
    .core_x    (core_x),
    .core_y    (core_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .err       (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled here, inputs changed here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send a word LSB first; gap inserts an idle cycle before bytes 1..3.
  // bad_idx selects a byte sent with wrong parity (-1 for none).
  task automatic send_word(input logic [31:0] w, input bit gap, input int bad_idx);
    for (int i = 0; i < 4; i++) begin
      if (gap && i > 0) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data  = w[8*i +: 8];
`ifdef HD_STAGER_PARITY_EN
      in_par   = (^w[8*i +: 8]) ^ (i == bad_idx);
`endif
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check_eq(tag, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bit ir_low;
    int ov_cnt;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
`ifdef HD_STAGER_PARITY_EN
    in_par    = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_data", out_data, 32'h0);
    check_eq("rst_core_x", core_x, 32'h0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);

    // Back-to-back word, out_ready high: out_valid exactly at T+4, for one cycle
    out_ready = 1'b1;
    send_word(32'h12345678, 1'b0, -1);
    check_eq("b2b_core_x", core_x, 32'h12345678);
    check_eq("b2b_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("b2b_busy", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      check_eq($sformatf("b2b_ov_t%0d", k), {31'd0, out_valid}, (k == 4) ? 32'd1 : 32'd0);
      if (k == 4) check_eq("b2b_out_data", out_data, 32'hF3DD1D3B);
      if (k < 5) tick();
    end
    check_eq("b2b_in_ready_after", {31'd0, in_ready}, 32'd1);
    check_eq("b2b_busy_after", {31'd0, busy}, 32'd0);

    // Same word with gaps between bytes
    send_word(32'h12345678, 1'b1, -1);
    check_eq("gap_core_x", core_x, 32'h12345678);
    ir_low = 1'b1;
    for (int n = 0; n < 20 && !out_valid; n++) begin
      if (in_ready) ir_low = 1'b0;
      tick();
    end
    check_eq("gap_in_ready_low", {31'd0, ir_low}, 32'd1);
    check_eq("gap_out_valid", {31'd0, out_valid}, 32'd1);
    check_eq("gap_out_data", out_data, 32'hF3DD1D3B);
    tick();
    check_eq("gap_drained", {31'd0, out_valid}, 32'd0);

    // Back-pressure: output held for 10 cycles
    out_ready = 1'b0;
    send_word(32'hCAFEF00D, 1'b0, -1);
    wait_valid("bp_wait");
    for (int k = 0; k < 10; k++) begin
      check_eq("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_out_data", out_data, 32'h55A8C5F1);
      check_eq("bp_core_x", core_x, 32'hCAFEF00D);
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check_eq("bp_release_ov", {31'd0, out_valid}, 32'd0);
    check_eq("bp_release_ir", {31'd0, in_ready}, 32'd1);

    // Reset after two bytes, then a fresh word
    in_valid = 1'b1;
    in_data  = 8'hAA;
`ifdef HD_STAGER_PARITY_EN
    in_par   = ^in_data;
`endif
    tick();
    in_data = 8'hBB;
`ifdef HD_STAGER_PARITY_EN
    in_par  = ^in_data;
`endif
    tick();
    in_valid = 1'b0;
    check_eq("abort_busy_pre", {31'd0, busy}, 32'd1);
    do_reset();
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_core_x", core_x, 32'h0);
    check_eq("abort_out_data", out_data, 32'h0);
    send_word(32'hDEADBEEF, 1'b0, -1);
    check_eq("abort_new_core_x", core_x, 32'hDEADBEEF);
    wait_valid("abort_wait");
    check_eq("abort_new_out", out_data, 32'h1B4AD1A2);
    tick();

    // Reset while draining
    out_ready = 1'b0;
    send_word(32'h12345678, 1'b0, -1);
    wait_valid("drain_wait");
    do_reset();
    check_eq("drain_rst_ov", {31'd0, out_valid}, 32'd0);
    check_eq("drain_rst_od", out_data, 32'h0);
    check_eq("drain_rst_cx", core_x, 32'h0);
    check_eq("drain_rst_ir", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;

`ifdef HD_STAGER_PARITY_EN
    // Second byte with bad parity: word dropped, err sticky
    send_word(32'h11223344, 1'b0, 1);
    check_eq("par_err", {31'd0, err}, 32'd1);
    check_eq("par_core_x", core_x, 32'h0);
    check_eq("par_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("par_busy", {31'd0, busy}, 32'd0);
    ov_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) ov_cnt++;
      tick();
    end
    check_eq("par_no_out", ov_cnt, 0);
    send_word(32'h12345678, 1'b0, -1);
    check_eq("par_clean_cx", core_x, 32'h12345678);
    wait_valid("par_clean_wait");
    check_eq("par_clean_out", out_data, 32'hF3DD1D3B);
    check_eq("par_err_sticky", {31'd0, err}, 32'd1);
    tick();
`else
    ov_cnt = 0;
    check_eq("noparity_err", {31'd0, err}, 32'(ov_cnt));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
